// File: rtl/scan_sel_gen.sv
// 3-bit decoder select scanner: wrap, ping-pong or single-sweep stepping with a div+1 prescaler.
// Optional `SCAN_SEL_GEN_BLANK_EN adds a registered blank = ~busy output.
module scan_sel_gen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic             A,
    output logic             B,
    output logic             Cin,
    output logic             busy,
    output logic             tick,
`ifdef SCAN_SEL_GEN_BLANK_EN
    output logic             blank,
`endif
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q;
    logic [2:0]       idx_q, idx_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pre_q;
    logic             busy_q, tick_q, done_q;
    logic             go, adv, at_end, halt;

    assign go     = (state_q == IDLE) && start && !stop;
    assign adv    = (pre_q == div_q);
    assign at_end = (mode_q == 2'b10) && (idx_q == (dir_q ? 3'd0 : 3'd7));
    assign halt   = (state_q == RUN) && (stop || (adv && at_end));

    // Ping-pong turns at the endpoints by stepping away and flipping the latched direction.
    always_comb begin
        idx_d = dir_q ? (idx_q - 3'd1) : (idx_q + 3'd1);
        dir_d = dir_q;
        if (mode_q == 2'b01) begin
            if (!dir_q && idx_q == 3'd7) begin
                idx_d = 3'd6;
                dir_d = 1'b1;
            end else if (dir_q && idx_q == 3'd0) begin
                idx_d = 3'd1;
                dir_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pre_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        idx_q   <= dir ? 3'd7 : 3'd0;
                        pre_q   <= '0;
                        dir_q   <= dir;
                        mode_q  <= mode;
                        div_q   <= div;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= !stop;
                        pre_q   <= adv ? '0 : pre_q;
                    end else if (adv) begin
                        pre_q  <= '0;
                        tick_q <= 1'b1;
                        idx_q  <= idx_d;
                        dir_q  <= dir_d;
                    end else begin
                        pre_q <= pre_q + DIV_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SCAN_SEL_GEN_BLANK_EN
    logic blank_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) blank_q <= 1'b1;
        else     blank_q <= !((busy_q || go) && !halt);
    end

    assign blank = blank_q;
`endif

    assign A    = idx_q[2];
    assign B    = idx_q[1];
    assign Cin  = idx_q[0];
    assign busy = busy_q;
    assign tick = tick_q;
    assign done = done_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Self-checking bench for scan_sel_gen: directed scenarios plus randomized runs against a position-based model.
// Builds with or without `SCAN_SEL_GEN_BLANK_EN.
module tb_scan_sel_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] div = 8'd0;
    logic       A, B, Cin, busy, tick, done;
    logic       blank_obs;
    logic [6:0] obs;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    scan_sel_gen #(.DIV_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .dir   (dir),
        .mode  (mode),
        .div   (div),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .tick  (tick),
`ifdef SCAN_SEL_GEN_BLANK_EN
        .blank (blank_obs),
`endif
        .done  (done)
    );

`ifndef SCAN_SEL_GEN_BLANK_EN
    assign blank_obs = ~busy;
`endif

    assign obs = {A, B, Cin, busy, tick, done, blank_obs};

    // Expected {index, busy, tick, done, blank} n cycles after the start edge.
    function automatic logic [6:0] model(input bit d, input bit [1:0] m,
                                         input int unsigned dv, input int unsigned n);
        int unsigned per = dv + 1;
        int unsigned k   = n / per;
        int unsigned pos;
        bit bz = 1'b1, tk, dn = 1'b0;
        tk = (n > 0) && (n % per == 0);
        if (m == 2'b10) begin
            if (k >= 8) begin
                k  = 7;
                bz = 1'b0;
                tk = 1'b0;
                dn = (n == 8 * per);
            end
            pos = k;
        end else if (m == 2'b01) begin
            pos = k % 14;
            if (pos > 7) pos = 14 - pos;
        end else begin
            pos = k % 8;
        end
        model = {(d ? 3'(7 - pos) : 3'(pos)), bz, tk, dn, ~bz};
    endfunction

    task automatic start_scan(input bit d, input bit [1:0] m, input int unsigned dv);
        start = 1'b1; stop = 1'b0; dir = d; mode = m; div = 8'(dv);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b000_0_0_0_1) $display("FAIL reset_async got=%b exp=%b", obs, 7'b0000001);
        else n_pass++;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 7'b000_0_0_0_1) $display("FAIL reset_hold got=%b exp=%b", obs, 7'b0000001);
        else n_pass++;
    endtask

    task automatic test_first_start();
        dir = 1'b0; mode = 2'b00; div = 8'd0;
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (obs !== model(1'b0, 2'b00, 0, 0)) $display("FAIL first_start got=%b exp=%b", obs, model(1'b0, 2'b00, 0, 0));
        else n_pass++;
        do_stop();
    endtask

    task automatic test_wrap_div0();
        start_scan(1'b0, 2'b00, 0);
        for (int unsigned n = 0; n < 12; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            n_checks++;
            if (obs !== model(1'b0, 2'b00, 0, n)) $display("FAIL wrap_div0 n=%0d got=%b exp=%b", n, obs, model(1'b0, 2'b00, 0, n));
            else n_pass++;
        end
        do_stop();
    endtask

    task automatic test_sweep_div2();
        start_scan(1'b0, 2'b10, 2);
        for (int unsigned n = 0; n < 28; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            n_checks++;
            if (obs !== model(1'b0, 2'b10, 2, n)) $display("FAIL sweep_div2 n=%0d got=%b exp=%b", n, obs, model(1'b0, 2'b10, 2, n));
            else n_pass++;
        end
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1; stop = 1'b1; dir = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        n_checks++;
        if (obs !== 7'b111_0_0_0_1) $display("FAIL start_stop_idle got=%b exp=%b", obs, 7'b1110001);
        else n_pass++;
    endtask

    task automatic test_pingpong_down();
        start_scan(1'b1, 2'b01, 1);
        for (int unsigned n = 0; n < 36; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            n_checks++;
            if (obs !== model(1'b1, 2'b01, 1, n)) $display("FAIL pingpong n=%0d got=%b exp=%b", n, obs, model(1'b1, 2'b01, 1, n));
            else n_pass++;
        end
        do_stop();
    endtask

    task automatic test_stop_at_4();
        start_scan(1'b0, 2'b00, 1);
        for (int unsigned n = 0; n < 10; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            n_checks++;
            if (obs !== model(1'b0, 2'b00, 1, n)) $display("FAIL stop4_run n=%0d got=%b exp=%b", n, obs, model(1'b0, 2'b00, 1, n));
            else n_pass++;
        end
        do_stop();
        n_checks++;
        if (obs !== 7'b100_0_0_0_1) $display("FAIL stop4_hold got=%b exp=%b", obs, 7'b1000001);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        start_scan(1'b0, 2'b00, 3);
        for (int unsigned n = 0; n < 24; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            n_checks++;
            if (obs !== model(1'b0, 2'b00, 3, n)) $display("FAIL midrun n=%0d got=%b exp=%b", n, obs, model(1'b0, 2'b00, 3, n));
            else n_pass++;
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b000_0_0_0_1) $display("FAIL midrun_async got=%b exp=%b", obs, 7'b0000001);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int unsigned n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== 7'b000_0_0_0_1) $display("FAIL midrun_after n=%0d got=%b exp=%b", n, obs, 7'b0000001);
            else n_pass++;
        end
    endtask

    task automatic test_random_runs();
        for (int unsigned it = 0; it < 14; it++) begin
            bit          d   = 1'($urandom);
            bit [1:0]    m   = 2'($urandom);
            int unsigned dv  = $urandom_range(0, 3);
            int unsigned per = dv + 1;
            int unsigned len = (m == 2'b10) ? 8 * per + 3 : $urandom_range(5, 40);
            logic [6:0]  e   = '0;
            start_scan(d, m, dv);
            for (int unsigned n = 0; n < len; n++) begin
                if (n > 0) begin @(posedge clk); #1; end
                e = model(d, m, dv, n);
                n_checks++;
                if (obs !== e) $display("FAIL random it=%0d n=%0d got=%b exp=%b", it, n, obs, e);
                else n_pass++;
                dir  = 1'($urandom);
                mode = 2'($urandom);
                div  = 8'($urandom);
                start = (m != 2'b10 || n + 1 < 8 * per) ? 1'($urandom) : 1'b0;
            end
            if (m != 2'b10) begin
                do_stop();
                start = 1'b0;
                n_checks++;
                if (obs !== {e[6:4], 4'b0001}) $display("FAIL random_stop it=%0d got=%b exp=%b", it, obs, {e[6:4], 4'b0001});
                else n_pass++;
            end
            start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_first_start();
        test_wrap_div0();
        test_sweep_div2();
        test_start_stop_idle();
        test_pingpong_down();
        test_stop_at_4();
        test_reset_midrun();
        test_random_runs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_sel_gen.md
SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

Interface
REQ-001 Parameter DIV_W, default 8: width of the step-prescaler divisor.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  level-sampled; begins a scan when the FSM is in IDLE.
REQ-005 stop  input  1  level-sampled; aborts a scan and returns the FSM to IDLE.
REQ-006 dir  input  1  0 = count up, 1 = count down; sampled only on an accepted start.
REQ-007 mode  input  2  00 = wrap, 01 = ping-pong, 10 = single sweep, 11 = same as 00; sampled only on an accepted start.
REQ-008 div  input  DIV_W  each position is held for div+1 cycles; sampled only on an accepted start.
REQ-009 A, B, Cin  output  1 each  registered 3-bit scan index; A = MSB, Cin = LSB; drives a 3-to-8 decoder select directly.
REQ-010 busy  output  1  high while the FSM is in RUN.
REQ-011 tick  output  1  one-cycle pulse in the cycle the index advances.
REQ-012 done  output  1  one-cycle pulse when a single sweep completes.

Function
REQ-013 FSM states: IDLE and RUN; busy = (state == RUN), registered.
REQ-014 IDLE to RUN: start=1 and stop=0. On that edge, load the index with 0 (dir=0) or 7 (dir=1), clear the prescaler, and latch dir, mode and div.
REQ-015 While in RUN, start is ignored.
REQ-016 stop=1 in RUN: go to IDLE on the same edge; the index holds its current value; tick=0 and done=0 in that cycle.
REQ-017 start=1 and stop=1 together in IDLE: stop wins; the FSM stays in IDLE and the index is unchanged.
REQ-018 Prescaler in RUN: counts 0..latched div. When it reaches latched div, it returns to 0, tick pulses and the index advances.
REQ-019 If latched div = 0, tick is high every RUN cycle.
REQ-020 The first advance occurs div+1 cycles after the start edge.
REQ-021 Wrap mode, up: 7 advances to 0. Wrap mode, down: 0 advances to 7. Runs until stop.
REQ-022 Ping-pong mode: the direction flips at the endpoints, so an up scan reads 0,1,...,7,6,...,1,0,1,... Each endpoint is emitted once per turn and is never repeated. Runs until stop.
REQ-023 Single-sweep mode: when tick fires at the terminal index (7 up, 0 down), the FSM goes to IDLE and done pulses in that cycle. The index stays at the terminal value and tick is suppressed on that final edge.
REQ-024 Single-sweep total occupancy is 8*(div+1) cycles from the start edge to the done cycle inclusive.
REQ-025 Index arithmetic is 3-bit modulo 8. No value outside 0..7 is ever produced.
REQ-026 A, B and Cin come straight from flops, with no combinational path from inputs to outputs.
REQ-027 Changes to div, dir or mode during RUN have no effect until the next accepted start.

Reset
REQ-028 While rst=1: state = IDLE; index = 0 (A=B=Cin=0); prescaler = 0; busy = tick = done = 0; latched dir = 0, latched mode = 00, latched div = 0.
REQ-029 Reset asserted mid-scan aborts the scan immediately, with no done pulse.
REQ-030 The first start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-031 With macro SCAN_SEL_GEN_BLANK_EN defined, add output blank (1 bit) = registered ~busy (reset value 1), so the downstream decoder outputs can be gated off while idle.
REQ-032 With SCAN_SEL_GEN_BLANK_EN undefined, the blank port and its flop are absent, and all other behaviour is identical.

Verification
REQ-033 Reset mid-RUN (div=3, index=5) -> A,B,Cin=000, busy=0, tick=0, done=0 asynchronously; no done pulse afterwards.
REQ-034 start with dir=0, mode=00, div=0 -> index 0,1,...,7,0,1 on consecutive cycles; tick high every RUN cycle; done never asserts.
REQ-035 start with dir=0, mode=10, div=2 -> each index 0..7 held 3 cycles; done pulses exactly 24 cycles after the start edge; then busy=0 and index=7.
REQ-036 start with dir=1, mode=01, div=1 -> sequence 7,6,...,0,1,...,7,6, each held 2 cycles; no repeated endpoint.
REQ-037 start and stop together in IDLE -> busy stays 0. stop at index 4 in wrap mode -> busy falls next edge, index holds 4, no tick.
REQ-038 With SCAN_SEL_GEN_BLANK_EN defined -> blank=1 out of reset, falls with busy on start, and rises on done or stop.
